seg_scan_capture: RTL and testbench

Read-back block for the fare display. It monitors the multiplexed common-anode seven-segment bus (active-low segments, active-low digit selects) that drives the panel. It waits for each digit's pattern to settle, decodes the pattern back to BCD and flags illegal patterns. When every digit position has been captured, it publishes a coherent frame. It sits beside the display driver and feeds self-check logic and the test bench with the value actually shown on the panel.

---
 rtl/seg_scan_capture.sv | 189 ++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
//
// Read-back monitor for a multiplexed common-anode seven-segment bus. Each
// digit's pattern must hold still for SETTLE cycles before it is captured. The
// pattern is then decoded back to BCD, and unknown patterns are flagged. Once
// every digit position has been captured, the block publishes a coherent frame.
//
// Parameters
//   DIGITS  number of multiplexed digit positions (1..8)
//   SETTLE  cycles the bus must hold unchanged before a capture (1..15)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg_in       segment bus, active-low, bit0=a .. bit6=g
//   an_in        digit selects, active-low, exactly one low when legal
//   bcd_out      published digits, digit i at [4i+3:4i] (4'hF blank, 4'hE bad)
//   digit_err    published per-digit illegal-pattern flags
//   all_nine     published frame reads 9 in every position
//   frame_valid  one-cycle pulse with each publish
// -----------------------------------------------------------------------------
module seg_scan_capture #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  all_nine,
  output logic                  frame_valid
);

  localparam int         BUS_W     = DIGITS + 7;
  localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } state_e;

  // Returns {err, bcd} for one active-low segment pattern.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = {1'b0, 4'h0};
      7'b1111001: decode = {1'b0, 4'h1};
      7'b0100100: decode = {1'b0, 4'h2};
      7'b0110000: decode = {1'b0, 4'h3};
      7'b0011001: decode = {1'b0, 4'h4};
      7'b0010010: decode = {1'b0, 4'h5};
      7'b0000010: decode = {1'b0, 4'h6};
      7'b1111000: decode = {1'b0, 4'h7};
      7'b0000000: decode = {1'b0, 4'h8};
      7'b0010000: decode = {1'b0, 4'h9};
      7'b1111111: decode = {1'b0, 4'hF};
      default:    decode = {1'b1, 4'hE};
    endcase
  endfunction

  logic [BUS_W-1:0]  bus;
  logic [BUS_W-1:0]  r_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              same;
  logic [DIGITS-1:0] sel_oh;
  logic              sel_ok;
  logic              cap;
  logic [DIGITS-1:0] cap_oh;
  logic [4:0]        dec;

  state_e            state_q, state_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              publish;

  logic [3:0]        sh_bcd_q [DIGITS];
  logic [DIGITS-1:0] sh_err_q;
  logic [4*DIGITS-1:0] sh_flat;
  logic              sh_nine;

  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   err_q;
  logic                nine_q;
  logic                fv_q;

  assign bus  = {an_in, seg_in};
  assign same = (bus == r_q);
  assign dec  = decode(seg_in);

  // A legal select has exactly one low bit: the inverted selects are a
  // nonzero power of two. The one-hot form doubles as the shadow write enable.
  assign sel_oh = ~an_in;
  assign sel_ok = (sel_oh != '0) && ((sel_oh & (sel_oh - 1'b1)) == '0);

  // The counter saturates at SETTLE, so the SETTLE-1 match (and the capture)
  // happens once per stable period.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    cnt_d = cnt_q;
    if (!same)                cnt_d = '0;
    else if (cnt_q != SETTLE_C) cnt_d = cnt_q + 4'd1;
  end

  assign cap    = same && (cnt_q == SETTLE_M1) && sel_ok;
  assign cap_oh = cap ? sel_oh : '0;

  // Next-state logic. Completion is judged on the mask that includes this
  // cycle's capture, so PUBLISH immediately follows the completing capture.
  // A capture in the PUBLISH cycle seeds the next frame's mask.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q | cap_oh;
    publish = 1'b0;
    case (state_q)
      COLLECT: if (&mask_d) state_d = PUBLISH;
      PUBLISH: begin
        publish = 1'b1;
        mask_d  = cap_oh;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    sh_nine = 1'b1;
    sh_flat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sh_flat[4*i +: 4] = sh_bcd_q[i];
      if (sh_bcd_q[i] != 4'h9 || sh_err_q[i]) sh_nine = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_q    <= '1;
      cnt_q  <= '0;
      mask_q <= '0;
      // NOTE: the shadow array is small and must read as blank after reset,
      // so it is reset explicitly rather than left to power-up contents.
      for (int i = 0; i < DIGITS; i++) sh_bcd_q[i] <= 4'hF;
      sh_err_q <= '0;
    end else begin
      r_q    <= bus;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      for (int i = 0; i < DIGITS; i++) begin
        if (cap_oh[i]) begin
          sh_bcd_q[i] <= dec[3:0];
          sh_err_q[i] <= dec[4];
        end
      end
    end
  end

  // Published registers load from pre-edge shadow contents, so a capture
  // landing on the publish edge affects only the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= '1;
      err_q  <= '0;
      nine_q <= 1'b0;
      fv_q   <= 1'b0;
    end else begin
      fv_q <= publish;
      if (publish) begin
        bcd_q  <= sh_flat;
        err_q  <= sh_err_q;
        nine_q <= sh_nine;
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = err_q;
  assign all_nine    = nine_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_capture
//
// Drives seg_scan_capture with directed scenarios and randomized bus traffic.
// A reference model tracks how many consecutive edges the current bus value has
// been seen and applies the frame rules to a shadow array. All published
// outputs are compared against the model after every edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_capture;

  localparam int DIGITS = 4;
  localparam int SETTLE = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   an_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_err;
  logic                all_nine;
  logic                frame_valid;

  seg_scan_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .bcd_out    (bcd_out),
    .digit_err  (digit_err),
    .all_nine   (all_nine),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_count = 0;
  int last_fv_cyc = -1;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;

  // Reference model state
  logic [DIGITS+6:0]   m_prev;
  int                  m_run;
  logic [3:0]          m_sh [DIGITS];
  logic [DIGITS-1:0]   m_err;
  logic [DIGITS-1:0]   m_mask;
  bit                  m_pending;
  logic [4*DIGITS-1:0] e_bcd;
  logic [DIGITS-1:0]   e_err;
  logic                e_nine;
  logic                e_fv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (s == pat[k]) return {1'b0, 4'(k)};
    if (s == BLANK) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  function automatic int zeros(input logic [DIGITS-1:0] a);
    int z = 0;
    for (int i = 0; i < DIGITS; i++) if (!a[i]) z++;
    return z;
  endfunction

  // One clock edge of the reference model. A value is captured when it has
  // been seen on SETTLE+1 consecutive edges; after reset the bus is treated
  // as having shown all ones once.
  task automatic model_edge();
    logic [DIGITS+6:0] cur;
    logic [4:0]        d;
    bit                cap;
    bit                pub;
    if (rst) begin
      m_prev = '1;
      m_run  = 1;
      for (int i = 0; i < DIGITS; i++) m_sh[i] = 4'hF;
      m_err = '0; m_mask = '0; m_pending = 0;
      e_bcd = '1; e_err = '0; e_nine = 1'b0; e_fv = 1'b0;
      return;
    end
    cur = {an_in, seg_in};
    if (cur == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = cur;
    cap = (m_run == SETTLE + 1) && (zeros(an_in) == 1);
    pub = m_pending;
    e_fv = pub;
    if (pub) begin
      e_nine = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        e_bcd[4*i +: 4] = m_sh[i];
        if (m_sh[i] != 4'h9 || m_err[i]) e_nine = 1'b0;
      end
      e_err = m_err;
      m_mask = '0;
      m_pending = 0;
    end
    if (cap) begin
      d = ref_decode(seg_in);
      for (int i = 0; i < DIGITS; i++) begin
        if (!an_in[i]) begin
          m_sh[i]   = d[3:0];
          m_err[i]  = d[4];
          m_mask[i] = 1'b1;
        end
      end
    end
    if (!pub && (&m_mask)) m_pending = 1;
  endtask

  task automatic tick(input logic r, input logic [DIGITS-1:0] a, input logic [6:0] s);
    rst = r; an_in = a; seg_in = s;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("bcd_out",     32'(bcd_out),     32'(e_bcd));
    check("digit_err",   32'(digit_err),   32'(e_err));
    check("all_nine",    32'(all_nine),    32'(e_nine));
    check("frame_valid", 32'(frame_valid), 32'(e_fv));
    if (frame_valid) begin
      fv_count++;
      last_fv_cyc = cyc;
    end
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    logic [DIGITS-1:0] a;
    a = ~(DIGITS'(1) << d);
    repeat (n) tick(1'b0, a, s);
  endtask

  initial begin
    int fv0;
    int t_last;
    rst = 1'b1; an_in = '1; seg_in = '1;

    // Reset with arbitrary bus contents
    repeat (2) tick(1'b1, DIGITS'($urandom), 7'($urandom));
    check("rst_bcd",  32'(bcd_out),     32'hFFFF);
    check("rst_err",  32'(digit_err),   32'h0);
    check("rst_nine", 32'(all_nine),    32'h0);
    check("rst_fv",   32'(frame_valid), 32'h0);

    // Normal frame: 3,5,0,1 on digits 0..3
    fv0 = fv_count;
    show(0, pat[3], 6);
    show(1, pat[5], 6);
    show(2, pat[0], 6);
    t_last = cyc + 1;
    show(3, pat[1], 6);
    check("normal_pulses",  32'(fv_count - fv0),       32'd1);
    check("normal_latency", 32'(last_fv_cyc - t_last), 32'd4);
    check("normal_bcd",     32'(bcd_out),              32'h1053);
    check("normal_err",     32'(digit_err),            32'h0);

    // Glitch rejection: a 3-cycle 8 between stable 5s on digit 0
    fv0 = fv_count;
    show(0, pat[5], 6);
    show(0, pat[8], 3);
    show(0, pat[5], 6);
    show(1, pat[4], 6);
    show(2, pat[2], 6);
    show(3, pat[6], 6);
    check("glitch_pulses", 32'(fv_count - fv0), 32'd1);
    check("glitch_digit0", 32'(bcd_out[3:0]),   32'h5);
    check("glitch_bcd",    32'(bcd_out),        32'h6245);

    // Illegal select interval, then an illegal pattern on digit 2
    fv0 = fv_count;
    show(0, pat[1], 6);
    show(1, pat[2], 6);
    show(3, pat[7], 6);
    repeat (10) tick(1'b0, 4'b1100, pat[8]);
    check("badsel_no_frame", 32'(fv_count - fv0), 32'd0);
    show(2, 7'b0101010, 6);
    check("illegal_pulses", 32'(fv_count - fv0), 32'd1);
    check("illegal_bcd",    32'(bcd_out),        32'h7E21);
    check("illegal_err",    32'(digit_err),      32'b0100);

    // Fare-max display, then a frame with one blank
    for (int d = 0; d < DIGITS; d++) show(d, pat[9], 6);
    check("max_bcd",  32'(bcd_out),  32'h9999);
    check("max_nine", 32'(all_nine), 32'h1);
    show(0, pat[9], 6);
    show(1, BLANK,  6);
    show(2, pat[9], 6);
    show(3, pat[9], 6);
    check("blank_bcd",  32'(bcd_out),   32'h99F9);
    check("blank_nine", 32'(all_nine),  32'h0);
    check("blank_err",  32'(digit_err), 32'h0);

    // Reset after two captures discards the partial frame
    fv0 = fv_count;
    show(0, pat[2], 6);
    show(1, pat[3], 6);
    repeat (2) tick(1'b1, '1, '1);
    show(2, pat[4], 6);
    show(3, pat[5], 6);
    check("rst_mid_no_frame", 32'(fv_count - fv0), 32'd0);
    show(0, pat[6], 6);
    show(1, pat[7], 6);
    check("rst_mid_frame", 32'(fv_count - fv0), 32'd1);
    check("rst_mid_bcd",   32'(bcd_out),        32'h5476);

    // Back-to-back frames: the next digit appears on the publish edge.
    // One bus cannot settle two values one edge apart, so its capture
    // lands on a later edge and the model tracks where it counts.
    fv0 = fv_count;
    show(0, pat[1], 6);
    show(1, pat[1], 6);
    show(2, pat[1], 6);
    show(3, pat[2], 4);
    show(0, pat[3], 6);
    show(1, pat[4], 6);
    show(2, pat[5], 6);
    show(3, pat[6], 6);
    check("b2b_pulses", 32'(fv_count - fv0), 32'd2);
    check("b2b_bcd",    32'(bcd_out),        32'h6543);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [DIGITS-1:0] a;
      logic [6:0]        s;
      int                len;
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(1, 2)) tick(1'b1, DIGITS'($urandom), 7'($urandom));
      end
      if ($urandom_range(0, 9) < 8) a = ~(DIGITS'(1) << $urandom_range(0, DIGITS - 1));
      else                          a = DIGITS'($urandom);
      case ($urandom_range(0, 11))
        0:       s = BLANK;
        1:       s = 7'($urandom);
        default: s = pat[$urandom_range(0, 9)];
      endcase
      len = $urandom_range(1, 7);
      repeat (len) tick(1'b0, a, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
